// File: rtl/mux_route_ctrl.sv
// mux_route_ctrl: byte-command controller for the console pin crossbar.
// Edits a shadow routing table and commits it atomically to the active map.
module mux_route_ctrl #(
   parameter int INPUT_COUNT  = 16,
   parameter int OUTPUT_COUNT = 16,
   localparam int SEL_W = $clog2(INPUT_COUNT)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [7:0]                    cmd_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [7:0]                    rsp_data,
   output logic [0:SEL_W*OUTPUT_COUNT-1] selectors,
   output logic                          dirty
);

   localparam int OUT_W = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;

   localparam logic [7:0] OP_SET    = 8'h01;
   localparam logic [7:0] OP_COMMIT = 8'h02;
   localparam logic [7:0] OP_CLEAR  = 8'h03;
   localparam logic [7:0] OP_READ   = 8'h04;

   localparam logic [7:0] ST_OK     = 8'h00;
   localparam logic [7:0] ST_BAD_OP = 8'hE1;
   localparam logic [7:0] ST_RANGE  = 8'hE2;

   typedef enum logic [2:0] {
      IDLE,
      ARG1,
      ARG2,
      EXEC,
      RESP
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [7:0] op_q;
   logic [7:0] out_q;
   logic [7:0] src_q;
   logic [7:0] rsp_q;

   logic [SEL_W-1:0] shadow [OUTPUT_COUNT];
   logic [SEL_W-1:0] active [OUTPUT_COUNT];

   logic             cmd_fire;
   logic             is_set;
   logic             is_commit;
   logic             is_clear;
   logic             is_read;
   logic             bad_out;
   logic             bad_src;
   logic [OUT_W-1:0] out_idx;
   logic [SEL_W-1:0] src_sel;

   function automatic logic [SEL_W-1:0] ident(input int i);
      return SEL_W'(i % INPUT_COUNT);
   endfunction

   assign cmd_fire  = cmd_valid & cmd_ready;
   assign is_set    = (op_q == OP_SET);
   assign is_commit = (op_q == OP_COMMIT);
   assign is_clear  = (op_q == OP_CLEAR);
   assign is_read   = (op_q == OP_READ);

   // Indices are range-checked at their full byte width before use.
   assign bad_out = int'(out_q) >= OUTPUT_COUNT;
   assign bad_src = int'(src_q) >= INPUT_COUNT;
   assign out_idx = out_q[OUT_W-1:0];
   assign src_sel = src_q[SEL_W-1:0];

   assign rsp_data = rsp_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_data == OP_SET || cmd_data == OP_READ) begin
                  state_d = ARG1;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         ARG1: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = is_set ? ARG2 : EXEC;
            end
         end
         ARG2: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Latch opcode and argument bytes as they are accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         out_q <= '0;
         src_q <= '0;
      end else if (cmd_fire) begin
         case (state_q)
            IDLE:    op_q  <= cmd_data;
            ARG1:    out_q <= cmd_data;
            ARG2:    src_q <= cmd_data;
            default: ;
         endcase
      end
   end

   // Execute the command against the tables and load the status byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_q <= '0;
         for (int i = 0; i < OUTPUT_COUNT; i++) begin
            shadow[i] <= ident(i);
            active[i] <= ident(i);
         end
      end else if (state_q == EXEC) begin
         unique case (1'b1)
            is_set: begin
               if (bad_out || bad_src) begin
                  rsp_q <= ST_RANGE;
               end else begin
                  shadow[out_idx] <= src_sel;
                  rsp_q           <= ST_OK;
               end
            end
            is_commit: begin
               for (int i = 0; i < OUTPUT_COUNT; i++) begin
                  active[i] <= shadow[i];
               end
               rsp_q <= ST_OK;
            end
            is_clear: begin
               for (int i = 0; i < OUTPUT_COUNT; i++) begin
                  shadow[i] <= ident(i);
               end
               rsp_q <= ST_OK;
            end
            is_read: begin
               if (bad_out) begin
                  rsp_q <= ST_RANGE;
               end else begin
                  rsp_q <= 8'(active[out_idx]);
               end
            end
            default: begin
               rsp_q <= ST_BAD_OP;
            end
         endcase
      end
   end

   // Uncommitted edits exist whenever any shadow entry differs from active.
   always_comb begin
      dirty = 1'b0;
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
         if (shadow[i] != active[i]) begin
            dirty = 1'b1;
         end
      end
   end

   // Pack the active map, output 0 in the leftmost field.
   always_comb begin
      selectors = '0;
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
         selectors[i*SEL_W +: SEL_W] = active[i];
      end
   end

endmodule

// File: tb/tb_mux_route_ctrl.sv
// tb_mux_route_ctrl: random and directed command streams for mux_route_ctrl,
// checked against an array-based model of the shadow/active routing tables.
module tb_mux_route_ctrl;

   localparam int IN_N  = 16;
   localparam int OUT_N = 16;
   localparam int W     = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [7:0]       cmd_data = 8'h00;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [7:0]       rsp_data;
   logic [0:W*OUT_N-1] selectors;
   logic             dirty;

   int checks = 0;
   int errors = 0;

   int sh [OUT_N];
   int ac [OUT_N];

   mux_route_ctrl #(
      .INPUT_COUNT (IN_N),
      .OUTPUT_COUNT(OUT_N)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_data (cmd_data),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .selectors(selectors),
      .dirty    (dirty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < OUT_N; i++) begin
         sh[i] = i % IN_N;
         ac[i] = i % IN_N;
      end
   endfunction

   function automatic logic [7:0] model_cmd(input logic [7:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
      if (op == 8'h01) begin
         if (a >= OUT_N || b >= IN_N) return 8'hE2;
         sh[a] = b;
         return 8'h00;
      end
      if (op == 8'h02) begin
         ac = sh;
         return 8'h00;
      end
      if (op == 8'h03) begin
         for (int i = 0; i < OUT_N; i++) sh[i] = i % IN_N;
         return 8'h00;
      end
      if (op == 8'h04) begin
         if (a >= OUT_N) return 8'hE2;
         return 8'(ac[a]);
      end
      return 8'hE1;
   endfunction

   function automatic logic model_dirty();
      for (int i = 0; i < OUT_N; i++) begin
         if (sh[i] != ac[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Output 0 is the most significant nibble of the packed bus.
   function automatic logic [63:0] model_sel();
      logic [63:0] v = '0;
      for (int i = 0; i < OUT_N; i++) begin
         v = (v << W) | 64'(ac[i]);
      end
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = b;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_cmd(input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int hold,
                         output logic [7:0] r);
      int n;
      int hh;
      logic [7:0] d0;
      n  = (op == 8'h01) ? 3 : (op == 8'h04) ? 2 : 1;
      hh = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      rsp_ready = 1'($urandom);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 1)) @(negedge clk);
         send_byte(k == 0 ? op : (k == 1 ? a : b));
      end
      rsp_ready = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
         cmd_valid = 1'b1;
         cmd_data  = 8'($urandom);
      end
      @(negedge clk);
      chk("lat_exec", rsp_valid, 0);
      chk("busy_exec", cmd_ready, 0);
      @(negedge clk);
      chk("lat_resp", rsp_valid, 1);
      chk("busy_resp", cmd_ready, 0);
      d0 = rsp_data;
      for (int h = 0; h < hh; h++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, d0);
         chk("hold_busy", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("post_ready", cmd_ready, 1);
      chk("post_valid", rsp_valid, 0);
      r = d0;
   endtask

   task automatic run(input string tag, input logic [7:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input int hold);
      logic [7:0] r;
      logic [7:0] e;
      do_cmd(op, a, b, hold, r);
      e = model_cmd(op, a, b);
      chk({tag, "_rsp"}, r, e);
      chk({tag, "_dirty"}, dirty, model_dirty());
      chk({tag, "_sel"}, selectors, model_sel());
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_sel"}, selectors, model_sel());
      chk({tag, "_dirty"}, dirty, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
   endtask

   initial begin
      int kind;
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;

      model_reset();
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      chk("reset_rsp_data", rsp_data, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      run("set3", 8'h01, 8'h03, 8'h0F, 0);
      run("commit", 8'h02, 8'h00, 8'h00, 0);
      run("bad_out", 8'h01, 8'h10, 8'h00, 0);
      run("bad_src", 8'h01, 8'h00, 8'h20, 0);
      run("unk_op", 8'h7F, 8'h00, 8'h00, 0);
      run("after_unk", 8'h02, 8'h00, 8'h00, 0);

      run("set5", 8'h01, 8'h05, 8'h09, 0);
      run("commit5", 8'h02, 8'h00, 8'h00, 0);
      run("set5b", 8'h01, 8'h05, 8'h02, 0);
      run("read5", 8'h04, 8'h05, 8'h00, 0);
      run("clear", 8'h03, 8'h00, 8'h00, 0);
      run("commit_id", 8'h02, 8'h00, 8'h00, 0);
      run("read5_id", 8'h04, 8'h05, 8'h00, 0);
      run("read_bad", 8'h04, 8'hFF, 8'h00, 0);
      run("commit_clean", 8'h02, 8'h00, 8'h00, 0);

      run("bp_set", 8'h01, 8'h01, 8'h0E, 10);
      run("bp_read", 8'h04, 8'h03, 8'h00, 10);

      run("pre_rst_set", 8'h01, 8'h07, 8'h01, 0);
      run("pre_rst_commit", 8'h02, 8'h00, 8'h00, 0);
      run("pre_rst_dirty", 8'h01, 8'h02, 8'h0B, 0);
      send_byte(8'h01);
      send_byte(8'h03);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_state("rst_arg");
      @(negedge clk);
      rst_n = 1'b1;
      run("rst_arg_commit", 8'h02, 8'h00, 8'h00, 0);

      run("pre_rsp_set", 8'h01, 8'h04, 8'h08, 0);
      run("pre_rsp_commit", 8'h02, 8'h00, 8'h00, 0);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h01);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_rsp_valid", rsp_valid, 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_state("rst_resp");
      @(negedge clk);
      rst_n = 1'b1;
      run("rst_resp_commit", 8'h02, 8'h00, 8'h00, 0);

      for (int t = 0; t < 300; t++) begin
         kind = int'($urandom_range(0, 9));
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                         : 8'($urandom_range(0, 15));
         b = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                         : 8'($urandom_range(0, 15));
         if (kind <= 3) begin
            op = 8'h01;
         end else if (kind == 4) begin
            op = 8'h02;
         end else if (kind == 5) begin
            op = 8'h03;
         end else if (kind <= 7) begin
            op = 8'h04;
         end else begin
            op = ($urandom_range(0, 4) == 0) ? 8'h00
                                             : 8'($urandom_range(5, 255));
         end
         run("rand", op, a, b, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
